act_skew_feeder: RTL and testbench



---
 rtl/act_skew_feeder_pkg.sv | 32 +++
 rtl/act_skew_feeder_delay.sv | 43 ++++
 rtl/act_skew_feeder.sv | 134 +++++++++++++
 tb/tb_act_skew_feeder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/act_skew_feeder_pkg.sv
// ---------------------------------------------------------------------------
// act_skew_feeder_pkg
//   Shared definitions for the activation skew feeder and the PE array it
//   drives: default activation width, feeder state encodings, and a clog2
//   helper that never returns less than 1 so counters always have a bit.
// ---------------------------------------------------------------------------
package act_skew_feeder_pkg;

    // Activation width shared with the PE active_left datapath
    localparam int DEFAULT_DW = 8;

    // Feeder control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feederState_t;

    // Ceiling log2 with a floor of 1 bit
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/act_skew_feeder_delay.sv
// ---------------------------------------------------------------------------
// skew_delay_line
//   Enable-gated shift register holding one row's data+valid. DEPTH stages;
//   the output is the last stage, so a value loaded at an EN-high edge shows
//   up on q after DEPTH EN-high edges (counting the load edge).
//
//   Ports:
//     CLK      in   rising-edge clock
//     RESET_N  in   asynchronous active-low reset, clears every stage
//     EN       in   shift enable; all stages hold while low
//     d        in   WIDTH  value loaded into stage 0
//     q        out  WIDTH  value of the final stage
// ---------------------------------------------------------------------------
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 9
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stages [DEPTH];

    // Shift chain: stage 0 takes d, every other stage takes its predecessor
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stages[i] <= '0;
            end
        end else if (EN) begin
            r_stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign q = r_stages[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// ---------------------------------------------------------------------------
// act_skew_feeder
//   Accepts one activation column per cycle over valid/ready and drives the
//   left edge of the systolic array with row r delayed by r cycles. After the
//   last vector of a tile the skew is flushed with zero bubbles and done
//   pulses in the cycle the bottom row shows its final element. Everything
//   freezes while EN is low.
//
//   Ports:
//     CLK        in   rising-edge clock
//     RESET_N    in   asynchronous active-low reset
//     EN         in   array enable; state holds while low
//     in_valid   in   in_vec carries a vector
//     in_ready   out  feeder can accept (EN high and not draining)
//     in_vec     in   ROWS*DW  element r at [r*DW +: DW]
//     in_last    in   last vector of the tile, qualified by accept
//     act_out    out  ROWS*DW  row r active_left value
//     act_valid  out  ROWS     per-row valid
//     busy       out  state is not IDLE
//     done       out  one-cycle end-of-tile pulse
// ---------------------------------------------------------------------------
module act_skew_feeder #(
    parameter int ROWS = 4,
    parameter int DW   = act_skew_feeder_pkg::DEFAULT_DW
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 EN,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   in_vec,
    input  logic                 in_last,
    output logic [ROWS*DW-1:0]   act_out,
    output logic [ROWS-1:0]      act_valid,
    output logic                 busy,
    output logic                 done
);

    import act_skew_feeder_pkg::*;

    localparam int CNT_W      = clog2(ROWS);
    // drain_cnt value seen on the final drain edge (ROWS-1 edges total)
    localparam int DRAIN_LAST = (ROWS > 1) ? (ROWS - 2) : 0;
    localparam logic [CNT_W-1:0] DRAIN_LAST_C = DRAIN_LAST[CNT_W-1:0];

    feederState_t     r_state;
    feederState_t     w_nextState;
    logic [CNT_W-1:0] r_drainCnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic             r_done;
    logic             w_doneSet;
    logic             w_accept;

    logic [DW:0]      w_stage0 [ROWS];
    logic [DW:0]      w_lineQ  [ROWS];

    assign in_ready = EN && (r_state != DRAIN);
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

    // Next-state logic; with EN low everything holds and done is not armed
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_drainCnt;
        w_doneSet   = 1'b0;
        if (EN) begin
            case (r_state)
                IDLE, STREAM: begin
                    if (w_accept) begin
                        if (in_last) begin
                            if (ROWS > 1) begin
                                w_nextState = DRAIN;
                                w_nextCnt   = '0;
                            end else begin
                                // Single row: nothing left to flush
                                w_nextState = IDLE;
                                w_doneSet   = 1'b1;
                            end
                        end else begin
                            w_nextState = STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (r_drainCnt == DRAIN_LAST_C) begin
                        w_nextState = IDLE;
                        w_nextCnt   = '0;
                        w_doneSet   = 1'b1;
                    end else begin
                        w_nextCnt = r_drainCnt + 1'b1;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    // State, drain counter and the done pulse; done self-clears on any edge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_drainCnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_drainCnt <= w_nextCnt;
            r_done     <= w_doneSet;
        end
    end

    // One delay line per row; row r is r+1 stages deep to form the wavefront
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign w_stage0[r] = w_accept ? {1'b1, in_vec[r*DW +: DW]} : '0;

        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (DW + 1)
        ) u_line (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .EN      (EN),
            .d       (w_stage0[r]),
            .q       (w_lineQ[r])
        );

        assign act_out[r*DW +: DW] = w_lineQ[r][DW-1:0];
        assign act_valid[r]        = w_lineQ[r][DW];
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_act_skew_feeder
//   Directed bench for the skew feeder: a 4-row instance exercises single
//   tiles, back-to-back vectors, bubbles, EN stalls and mid-drain reset; a
//   1-row instance exercises the direct last-accept-to-done path.
// ---------------------------------------------------------------------------
module tb_act_skew_feeder;

    logic        CLK;
    logic        RESET_N;

    logic        en4, valid4, last4;
    logic [31:0] vec4;
    logic        ready4, busy4, done4;
    logic [31:0] act4;
    logic [3:0]  vld4;

    logic        en1, valid1, last1;
    logic [7:0]  vec1;
    logic        ready1, busy1, done1;
    logic [7:0]  act1;
    logic [0:0]  vld1;

    int nCompared   = 0;
    int nMismatched = 0;

    act_skew_feeder #(.ROWS(4), .DW(8)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .EN(en4),
        .in_valid(valid4), .in_ready(ready4), .in_vec(vec4), .in_last(last4),
        .act_out(act4), .act_valid(vld4), .busy(busy4), .done(done4)
    );

    act_skew_feeder #(.ROWS(1), .DW(8)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .EN(en1),
        .in_valid(valid1), .in_ready(ready1), .in_vec(vec1), .in_last(last1),
        .act_out(act1), .act_valid(vld1), .busy(busy1), .done(done1)
    );

    // Free-running clock, 10 ns period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance past one rising edge and settle
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        en4 = 1'b1; valid4 = 1'b0; last4 = 1'b0; vec4 = '0;
        en1 = 1'b1; valid1 = 1'b0; last1 = 1'b0; vec1 = '0;
        #3;
        nCompared++; if (act4 !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_act4 got=%h exp=%h", act4, 32'h0); end
        nCompared++; if (vld4 !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_vld4 got=%b exp=%b", vld4, 4'h0); end
        nCompared++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy_done4 got=%b%b exp=00", busy4, done4); end
        nCompared++; if (act1 !== 8'h0 || vld1 !== 1'b0 || done1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_dut1 got=%h/%b/%b exp=00/0/0", act1, vld1, done1); end
        tick();
        RESET_N = 1'b1;
        tick();
        nCompared++; if (ready4 !== 1'b1 || ready1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready got=%b%b exp=11", ready4, ready1); end
    endtask

    // Single vector {1,2,3,4} with last; rows appear one per cycle, done with row 3
    task automatic test_single(input string tag);
        logic [31:0] expAct;
        logic [3:0]  expVld;
        nCompared++; if (ready4 !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s_ready_pre got=%b exp=1", tag, ready4); end
        valid4 = 1'b1; vec4 = 32'h04030201; last4 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            valid4 = 1'b0; last4 = 1'b0; vec4 = '0;
            expAct = 32'(j + 1) << (8 * j);
            expVld = 4'(1 << j);
            nCompared++; if (act4 !== expAct) begin nMismatched++; $display("[TB] FAIL %s_act j=%0d got=%h exp=%h", tag, j, act4, expAct); end
            nCompared++; if (vld4 !== expVld) begin nMismatched++; $display("[TB] FAIL %s_vld j=%0d got=%b exp=%b", tag, j, vld4, expVld); end
            nCompared++; if (busy4 !== (j < 3)) begin nMismatched++; $display("[TB] FAIL %s_busy j=%0d got=%b exp=%b", tag, j, busy4, (j < 3)); end
            nCompared++; if (done4 !== (j == 3)) begin nMismatched++; $display("[TB] FAIL %s_done j=%0d got=%b exp=%b", tag, j, done4, (j == 3)); end
            nCompared++; if (ready4 !== (j == 3)) begin nMismatched++; $display("[TB] FAIL %s_ready j=%0d got=%b exp=%b", tag, j, ready4, (j == 3)); end
        end
        tick();
        nCompared++; if (done4 !== 1'b0 || vld4 !== 4'h0) begin nMismatched++; $display("[TB] FAIL %s_after got=%b/%b exp=0/0000", tag, done4, vld4); end
    endtask

    // Three consecutive vectors, last on the third
    task automatic test_back_to_back();
        logic [31:0] expAct;
        logic [3:0]  expVld;
        int d;
        for (int j = 0; j < 6; j++) begin
            if (j < 3) begin
                nCompared++; if (ready4 !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_ready j=%0d got=%b exp=1", j, ready4); end
                valid4 = 1'b1; vec4 = 32'(j + 1) * 32'h01010101; last4 = (j == 2);
            end else begin
                valid4 = 1'b0; vec4 = '0; last4 = 1'b0;
            end
            tick();
            expAct = '0; expVld = '0;
            for (int r = 0; r < 4; r++) begin
                d = j - r;
                if (d >= 0 && d <= 2) begin
                    expAct[8*r +: 8] = 8'(d + 1);
                    expVld[r] = 1'b1;
                end
            end
            nCompared++; if (act4 !== expAct) begin nMismatched++; $display("[TB] FAIL b2b_act j=%0d got=%h exp=%h", j, act4, expAct); end
            nCompared++; if (vld4 !== expVld) begin nMismatched++; $display("[TB] FAIL b2b_vld j=%0d got=%b exp=%b", j, vld4, expVld); end
            nCompared++; if (done4 !== (j == 5)) begin nMismatched++; $display("[TB] FAIL b2b_done j=%0d got=%b exp=%b", j, done4, (j == 5)); end
        end
        valid4 = 1'b0;
        tick();
    endtask

    // Vector A, one idle cycle, then vector B with last
    task automatic test_bubble();
        logic [31:0] expAct;
        logic [3:0]  expVld;
        int d;
        for (int j = 0; j < 6; j++) begin
            valid4 = 1'b0; vec4 = '0; last4 = 1'b0;
            if (j == 0) begin valid4 = 1'b1; vec4 = 32'hA3A2A1A0; end
            if (j == 2) begin valid4 = 1'b1; vec4 = 32'hB3B2B1B0; last4 = 1'b1; end
            tick();
            expAct = '0; expVld = '0;
            for (int r = 0; r < 4; r++) begin
                d = j - r;
                if (d == 0) begin expAct[8*r +: 8] = 8'hA0 + 8'(r); expVld[r] = 1'b1; end
                if (d == 2) begin expAct[8*r +: 8] = 8'hB0 + 8'(r); expVld[r] = 1'b1; end
            end
            nCompared++; if (act4 !== expAct) begin nMismatched++; $display("[TB] FAIL bubble_act j=%0d got=%h exp=%h", j, act4, expAct); end
            nCompared++; if (vld4 !== expVld) begin nMismatched++; $display("[TB] FAIL bubble_vld j=%0d got=%b exp=%b", j, vld4, expVld); end
            nCompared++; if (done4 !== (j == 5)) begin nMismatched++; $display("[TB] FAIL bubble_done j=%0d got=%b exp=%b", j, done4, (j == 5)); end
        end
        valid4 = 1'b0; last4 = 1'b0;
        tick();
    endtask

    // EN dropped for two cycles mid-drain; done arrives two cycles late
    task automatic test_en_stall();
        valid4 = 1'b1; vec4 = 32'h04030201; last4 = 1'b1;
        tick();
        valid4 = 1'b0; last4 = 1'b0; vec4 = '0;
        tick();
        nCompared++; if (vld4 !== 4'b0010 || act4 !== 32'h00000200) begin nMismatched++; $display("[TB] FAIL stall_pre got=%b/%h exp=0010/00000200", vld4, act4); end
        en4 = 1'b0;
        #1;
        nCompared++; if (ready4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_ready got=%b exp=0", ready4); end
        for (int j = 0; j < 2; j++) begin
            tick();
            nCompared++; if (vld4 !== 4'b0010 || act4 !== 32'h00000200) begin nMismatched++; $display("[TB] FAIL stall_hold j=%0d got=%b/%h exp=0010/00000200", j, vld4, act4); end
            nCompared++; if (busy4 !== 1'b1 || done4 !== 1'b0 || ready4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_ctrl j=%0d got=%b%b%b exp=100", j, busy4, done4, ready4); end
        end
        en4 = 1'b1;
        tick();
        nCompared++; if (vld4 !== 4'b0100 || act4 !== 32'h00030000 || done4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_resume got=%b/%h/%b exp=0100/00030000/0", vld4, act4, done4); end
        tick();
        nCompared++; if (vld4 !== 4'b1000 || act4 !== 32'h04000000 || done4 !== 1'b1 || busy4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_done got=%b/%h/%b/%b exp=1000/04000000/1/0", vld4, act4, done4, busy4); end
        // done must clear on the next edge even with EN low; row 3 value persists
        en4 = 1'b0;
        tick();
        nCompared++; if (done4 !== 1'b0 || vld4 !== 4'b1000 || act4 !== 32'h04000000) begin nMismatched++; $display("[TB] FAIL stall_doneclr got=%b/%b/%h exp=0/1000/04000000", done4, vld4, act4); end
        en4 = 1'b1;
        tick();
        nCompared++; if (vld4 !== 4'b0000) begin nMismatched++; $display("[TB] FAIL stall_flush got=%b exp=0000", vld4); end
    endtask

    // Asynchronous reset in the middle of DRAIN discards everything
    task automatic test_reset_mid_drain();
        valid4 = 1'b1; vec4 = 32'h04030201; last4 = 1'b1;
        tick();
        valid4 = 1'b0; last4 = 1'b0; vec4 = '0;
        tick();
        #1;
        RESET_N = 1'b0;
        #1;
        nCompared++; if (act4 !== 32'h0 || vld4 !== 4'h0) begin nMismatched++; $display("[TB] FAIL rstmid_data got=%h/%b exp=00000000/0000", act4, vld4); end
        nCompared++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_ctrl got=%b%b exp=00", busy4, done4); end
        #2;
        RESET_N = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            nCompared++; if (done4 !== 1'b0 || vld4 !== 4'h0) begin nMismatched++; $display("[TB] FAIL rstmid_quiet j=%0d got=%b/%b exp=0/0000", j, done4, vld4); end
        end
        test_single("rstmid_single");
    endtask

    // Single-row feeder: last accept goes straight to done
    task automatic test_rows1();
        nCompared++; if (ready1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL rows1_ready_pre got=%b exp=1", ready1); end
        valid1 = 1'b1; vec1 = 8'hFB; last1 = 1'b1;
        tick();
        nCompared++; if (act1 !== 8'hFB || vld1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL rows1_data got=%h/%b exp=fb/1", act1, vld1); end
        nCompared++; if (done1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL rows1_ctrl got=%b%b%b exp=101", done1, busy1, ready1); end
        // New tile accepted in the done cycle
        vec1 = 8'h7F;
        tick();
        nCompared++; if (act1 !== 8'h7F || vld1 !== 1'b1 || done1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL rows1_next got=%h/%b/%b exp=7f/1/1", act1, vld1, done1); end
        valid1 = 1'b0; last1 = 1'b0; vec1 = '0;
        tick();
        nCompared++; if (vld1 !== 1'b0 || done1 !== 1'b0 || ready1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL rows1_idle got=%b%b%b exp=001", vld1, done1, ready1); end
    endtask

    initial begin
        test_reset();
        test_single("single");
        test_back_to_back();
        test_bubble();
        test_en_stall();
        test_reset_mid_drain();
        test_rows1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
